// File: rtl/atconv_engine.sv
// Atrous 3x3 convolution engine: dilated edge-style kernel with bias, replicate
// padding and ReLU into layer-1 RAM, then optional 2x2 max-pool with round-up into layer-2 RAM.
module atconv_engine #(
  parameter  int IMG_W = 64,
  parameter  int DW    = 13,
  parameter  int FRAC  = 4,
  localparam int AW    = 2 * $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  input  logic [2:0]    dil,
  input  logic [DW-1:0] bias,
  input  logic          pool_en,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] iaddr,
  input  logic [DW-1:0] idata,
  output logic          csel,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr
);

  localparam int LW   = AW / 2;
  localparam int ACCW = DW + 6;
  localparam logic signed [LW+1:0]   CMAX    = (LW+2)'(IMG_W - 1);
  localparam logic signed [ACCW-1:0] RMAX    = ACCW'((1 << DW) - 1);
  localparam logic [DW-1:0]          LOWMASK = DW'((1 << FRAC) - 1);
  localparam logic [DW-1:0]          PMAX    = DW'((1 << DW) - (1 << FRAC));
  localparam logic [DW:0]            PSTEP   = (DW+1)'(1 << FRAC);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONV_RD = 3'd1,
    CONV_WR = 3'd2,
    POOL_RD = 3'd3,
    POOL_WR = 3'd4,
    FIN     = 3'd5
  } state_t;

  state_t                  state_r;
  logic [2:0]              dil_r;
  logic [DW-1:0]           bias_r;
  logic                    pool_en_r;
  logic [AW-1:0]           pix_r;
  logic [AW-3:0]           blk_r;
  logic [3:0]              step_r;
  logic signed [ACCW-1:0]  acc_r;
  logic [DW-1:0]           max_r;

  logic [2:0]              dil_eff_s;
  logic signed [ACCW-1:0]  acc_bias_s;
  logic signed [ACCW-1:0]  acc_sum_s;
  logic [DW-1:0]           max_s;

  function automatic logic [LW-1:0] clamp_coord(input logic signed [LW+1:0] v);
    if (v[LW+1]) begin
      clamp_coord = '0;
    end else if (v > CMAX) begin
      clamp_coord = LW'(IMG_W - 1);
    end else begin
      clamp_coord = v[LW-1:0];
    end
  endfunction

  // Tap k walks the 3x3 window row-major starting at dy=-1, dx=-1.
  function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] pix, input logic [3:0] k,
                                             input logic [2:0] d);
    logic signed [LW+1:0] rs, cs, ds;
    rs = $signed({2'b00, pix[AW-1:LW]});
    cs = $signed({2'b00, pix[LW-1:0]});
    ds = $signed({{(LW-1){1'b0}}, d});
    case (k)
      4'd0, 4'd1, 4'd2: rs = rs - ds;
      4'd6, 4'd7, 4'd8: rs = rs + ds;
      default:          rs = rs;
    endcase
    case (k)
      4'd0, 4'd3, 4'd6: cs = cs - ds;
      4'd2, 4'd5, 4'd8: cs = cs + ds;
      default:          cs = cs;
    endcase
    tap_addr = {clamp_coord(rs), clamp_coord(cs)};
  endfunction

  function automatic logic signed [ACCW-1:0] tap_term(input logic [3:0] k, input logic [DW-1:0] x);
    logic signed [ACCW-1:0] xs;
    xs = $signed({6'b000000, x});
    case (k)
      4'd4:                   tap_term = xs <<< 4;
      4'd0, 4'd2, 4'd6, 4'd8: tap_term = -xs;
      4'd1, 4'd7:             tap_term = -(xs <<< 1);
      4'd3, 4'd5:             tap_term = -(xs <<< 2);
      default:                tap_term = '0;
    endcase
  endfunction

  function automatic logic [DW-1:0] conv_out(input logic signed [ACCW-1:0] acc);
    logic signed [ACCW-1:0] sh;
    sh = acc >>> 4;
    if (sh[ACCW-1]) begin
      conv_out = '0;
    end else if (sh > RMAX) begin
      conv_out = '1;
    end else begin
      conv_out = sh[DW-1:0];
    end
  endfunction

  function automatic logic [DW-1:0] pool_out(input logic [DW-1:0] m);
    logic [DW:0] up;
    if (|(m & LOWMASK)) begin
      up = {1'b0, m & ~LOWMASK} + PSTEP;
    end else begin
      up = {1'b0, m};
    end
    if (up > {1'b0, PMAX}) begin
      pool_out = PMAX;
    end else begin
      pool_out = up[DW-1:0];
    end
  endfunction

  function automatic logic [AW-1:0] pool_addr(input logic [AW-3:0] blk, input logic [1:0] j);
    pool_addr = {blk[AW-3:LW-1], j[1], blk[LW-2:0], j[0]};
  endfunction

  assign dil_eff_s  = (dil == 3'd0) ? 3'd1 : dil;
  assign acc_bias_s = $signed({{6{bias_r[DW-1]}}, bias_r}) <<< 4;
  // Data for the tap issued last cycle arrives now, so step_r-1 names its weight.
  assign acc_sum_s  = acc_r + tap_term(step_r - 4'd1, idata);
  assign max_s      = (cdata_rd > max_r) ? cdata_rd : max_r;

  // Job sequencer: convolution pass, optional pooling pass, completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      dil_r     <= 3'd1;
      bias_r    <= '0;
      pool_en_r <= 1'b0;
      pix_r     <= '0;
      blk_r     <= '0;
      step_r    <= 4'd0;
      acc_r     <= '0;
      max_r     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      iaddr     <= '0;
      csel      <= 1'b0;
      crd       <= 1'b0;
      caddr_rd  <= '0;
      cwr       <= 1'b0;
      caddr_wr  <= '0;
      cdata_wr  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (ready) begin
            dil_r     <= dil_eff_s;
            bias_r    <= bias;
            pool_en_r <= pool_en;
            busy      <= 1'b1;
            pix_r     <= '0;
            step_r    <= 4'd0;
            iaddr     <= tap_addr('0, 4'd0, dil_eff_s);
            state_r   <= CONV_RD;
          end
        end
        CONV_RD: begin
          step_r <= step_r + 4'd1;
          if (step_r == 4'd0) begin
            acc_r <= acc_bias_s;
          end else begin
            acc_r <= acc_sum_s;
          end
          if (step_r < 4'd8) begin
            iaddr <= tap_addr(pix_r, step_r + 4'd1, dil_r);
          end
          if (step_r == 4'd9) begin
            cwr      <= 1'b1;
            csel     <= 1'b0;
            caddr_wr <= pix_r;
            cdata_wr <= conv_out(acc_sum_s);
            state_r  <= CONV_WR;
          end
        end
        CONV_WR: begin
          cwr    <= 1'b0;
          step_r <= 4'd0;
          if (&pix_r) begin
            if (pool_en_r) begin
              blk_r    <= '0;
              crd      <= 1'b1;
              caddr_rd <= pool_addr('0, 2'd0);
              state_r  <= POOL_RD;
            end else begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= FIN;
            end
          end else begin
            pix_r   <= pix_r + AW'(1);
            iaddr   <= tap_addr(pix_r + AW'(1), 4'd0, dil_r);
            state_r <= CONV_RD;
          end
        end
        POOL_RD: begin
          step_r <= step_r + 4'd1;
          if (step_r == 4'd0) begin
            max_r <= '0;
          end else begin
            max_r <= max_s;
          end
          if (step_r < 4'd3) begin
            caddr_rd <= pool_addr(blk_r, step_r[1:0] + 2'd1);
          end
          if (step_r == 4'd3) begin
            crd <= 1'b0;
          end
          if (step_r == 4'd4) begin
            cwr      <= 1'b1;
            csel     <= 1'b1;
            caddr_wr <= {2'b00, blk_r};
            cdata_wr <= pool_out(max_s);
            state_r  <= POOL_WR;
          end
        end
        POOL_WR: begin
          cwr    <= 1'b0;
          csel   <= 1'b0;
          step_r <= 4'd0;
          if (&blk_r) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= FIN;
          end else begin
            blk_r    <= blk_r + (AW-2)'(1);
            crd      <= 1'b1;
            caddr_rd <= pool_addr(blk_r + (AW-2)'(1), 2'd0);
            state_r  <= POOL_RD;
          end
        end
        FIN: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          cwr     <= 1'b0;
          crd     <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_atconv_engine.sv
// Scoreboard bench for atconv_engine at IMG_W=8: a plain-arithmetic reference
// model queues the expected layer writes, a monitor pops them as the DUT writes.
module tb_atconv_engine;
  localparam int W  = 8;
  localparam int N  = W * W;
  localparam int AW = 6;
  localparam int DW = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ready = 1'b0;
  logic [2:0]    dil = 3'd0;
  logic [DW-1:0] bias = '0;
  logic          pool_en = 1'b0;
  logic          busy, done, csel, crd, cwr;
  logic [AW-1:0] iaddr, caddr_rd, caddr_wr;
  logic [DW-1:0] idata, cdata_rd, cdata_wr;

  logic [DW-1:0] img [N];
  logic [DW-1:0] l1  [N];
  logic [DW-1:0] l2  [N/4];

  int passed = 0;
  int total  = 0;

  typedef struct { int sel; int addr; int data; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  atconv_engine #(.IMG_W(W), .DW(DW), .FRAC(4)) dut (
    .clk(clk), .reset(reset), .ready(ready), .dil(dil), .bias(bias), .pool_en(pool_en),
    .busy(busy), .done(done), .iaddr(iaddr), .idata(idata), .csel(csel), .crd(crd),
    .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) idata <= img[iaddr];

  always @(posedge clk) begin
    if (crd) cdata_rd <= csel ? l2[caddr_rd[3:0]] : l1[caddr_rd];
    if (cwr) begin
      if (csel) l2[caddr_wr[3:0]] <= cdata_wr;
      else      l1[caddr_wr] <= cdata_wr;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  function automatic int clampi(input int v);
    return (v < 0) ? 0 : ((v > W - 1) ? W - 1 : v);
  endfunction

  function automatic int weight(input int dy, input int dx);
    if (dy == 0 && dx == 0) return 16;
    if (dy == 0) return -4;
    if (dx == 0) return -2;
    return -1;
  endfunction

  // Reference: weighted sum in 1/16 units, ReLU/saturate, then 2x2 max with round-up.
  task automatic push_model(input int dl, input int bs, input bit pen);
    int b, acc, v, m;
    int res[N];
    wr_t e;
    b = (bs >= 4096) ? bs - 8192 : bs;
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W; c++) begin
        acc = 16 * b;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            acc += weight(dy, dx) * int'(img[clampi(r + dy * dl) * W + clampi(c + dx * dl)]);
        v = (acc < 0) ? 0 : acc / 16;
        if (v > 8191) v = 8191;
        res[r * W + c] = v;
        e.sel = 0; e.addr = r * W + c; e.data = v;
        exp_q.push_back(e);
      end
    end
    if (pen) begin
      for (int rb = 0; rb < W / 2; rb++) begin
        for (int cb = 0; cb < W / 2; cb++) begin
          m = 0;
          for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
              if (res[(2 * rb + i) * W + 2 * cb + j] > m) m = res[(2 * rb + i) * W + 2 * cb + j];
          v = ((m + 15) / 16) * 16;
          if (v > 8176) v = 8176;
          e.sel = 1; e.addr = rb * (W / 2) + cb; e.data = v;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset && cwr) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: sel=%0d addr=%0d data=%0d, required no write", csel, caddr_wr, cdata_wr);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_sel",  int'(csel),     mon_e.sel);
        check("wr_addr", int'(caddr_wr), mon_e.addr);
        check("wr_data", int'(cdata_wr), mon_e.data);
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, " busy"},     int'(busy),     0);
    check({tag, " done"},     int'(done),     0);
    check({tag, " cwr"},      int'(cwr),      0);
    check({tag, " crd"},      int'(crd),      0);
    check({tag, " csel"},     int'(csel),     0);
    check({tag, " iaddr"},    int'(iaddr),    0);
    check({tag, " caddr_rd"}, int'(caddr_rd), 0);
    check({tag, " caddr_wr"}, int'(caddr_wr), 0);
    check({tag, " cdata_wr"}, int'(cdata_wr), 0);
  endtask

  task automatic start_job(input int dl, input int bs, input bit pen);
    @(negedge clk);
    dil = 3'(dl); bias = 13'(bs); pool_en = pen; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic run_job(input string name, input int dl, input int model_dl, input int bs, input bit pen);
    int cnt;
    push_model(model_dl, bs, pen);
    start_job(dl, bs, pen);
    cnt = 0;
    while (busy && cnt < 5000) begin
      cnt++;
      @(negedge clk);
    end
    check({name, " busy_cycles"}, cnt, N * 11 + (pen ? (N / 4) * 6 : 0));
    check({name, " done_at_fall"}, int'(done), 1);
    check({name, " writes_left"}, exp_q.size(), 0);
    exp_q.delete();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check({name, " done_one_cycle"}, int'(done), 0);
    @(negedge clk);
    check({name, " fin_ready_ignored"}, int'(busy), 0);
  endtask

  task automatic fill_img(input int v);
    for (int i = 0; i < N; i++) img[i] = 13'(v);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) img[i] = 13'($urandom_range(0, 8191));
  endtask

  initial begin
    int dl, bs;
    bit pen;
    fill_img(0);
    for (int i = 0; i < N; i++) l1[i] = '0;
    for (int i = 0; i < N / 4; i++) l2[i] = '0;
    #12;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b0;

    fill_img(16);
    run_job("flat_bias_neg", 2, 2, -12, 1'b1);

    fill_img(0); img[36] = 13'h100;
    run_job("impulse_mid", 2, 2, 0, 1'b1);
    check("impulse_mid l1[4,4]", int'(l1[36]), 256);
    check("impulse_mid l2[2,2]", int'(l2[10]), 256);

    fill_img(0); img[0] = 13'h100;
    run_job("impulse_corner", 2, 2, 0, 1'b0);
    check("impulse_corner l1[0,0]", int'(l1[0]), 144);

    fill_img(0);
    run_job("zero_bias3", 1, 1, 3, 1'b1);
    check("zero_bias3 l1[7,7]", int'(l1[63]), 3);
    check("zero_bias3 l2[3,3]", int'(l2[15]), 16);

    fill_img(0); img[27] = 13'h1FFF;
    run_job("saturate", 1, 1, 13'h0FFF, 1'b1);
    check("saturate l1[3,3]", int'(l1[27]), 8191);
    check("saturate l2[1,1]", int'(l2[5]), 8176);

    for (int t = 0; t < 3; t++) begin
      fill_rand();
      dl  = $urandom_range(0, 7);
      bs  = $urandom_range(0, 8191);
      pen = 1'($urandom_range(0, 1));
      run_job($sformatf("random%0d", t), dl, (dl == 0) ? 1 : dl, bs, pen);
    end

    fill_rand();
    push_model(3, 100, 1'b1);
    start_job(3, 100, 1'b1);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("mid_reset");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_job("dil0_after_reset", 0, 1, $urandom_range(0, 8191), 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
